// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the multi-cycle chunked adder:
//   - state_t       : controller state encoding (IDLE, RUN, DONE)
//   - DEFAULT_WIDTH : default operand/sum width
//   - DEFAULT_CHUNK : default number of bits added per clock
//   - MIN_WIDTH / MAX_WIDTH : legal operand width range
// -----------------------------------------------------------------------------
package adder_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CHUNK = 2;
  localparam int MIN_WIDTH     = 2;
  localparam int MAX_WIDTH     = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/chunk_adder.sv
// -----------------------------------------------------------------------------
// chunk_adder
// Purely combinational CHUNK-bit ripple slice used once per RUN cycle.
//
// Parameters:
//   CHUNK : slice width in bits (>= 1)
// Ports:
//   a, b  : in  [CHUNK-1:0] slice operands
//   cin   : in  carry into bit 0 of the slice
//   s     : out [CHUNK-1:0] slice sum
//   cout  : out carry out of the slice MSB
//   c_msb : out carry into the slice MSB (needed for signed overflow)
// -----------------------------------------------------------------------------
module chunk_adder #(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign s     = total[CHUNK-1:0];
  assign cout  = total[CHUNK];

  // The MSB sum bit is a ^ b ^ carry_in, so the carry into the MSB falls out
  // of the sum without a second adder. For CHUNK=1 this is simply cin.
  assign c_msb = s[CHUNK-1] ^ a[CHUNK-1] ^ b[CHUNK-1];

endmodule

// File: rtl/multicycle_adder.sv
// -----------------------------------------------------------------------------
// multicycle_adder
// Adds two WIDTH-bit operands CHUNK bits per clock using a single chunk_adder
// slice. N = WIDTH/CHUNK RUN cycles per addition; done pulses for one cycle
// when the result is valid, and results hold until the next accepted start.
//
// Optional feature (macro SUBTRACT_EN): adds input 'sub'. With sub=1 the
// operation is a + ~b + 1 (c_in ignored); carry=1 then means "no borrow".
//
// Parameters:
//   WIDTH : operand/sum width, 2..64
//   CHUNK : bits added per clock, must divide WIDTH
// Ports:
//   clk      : in  clock, rising edge
//   rst_n    : in  asynchronous active-low reset
//   start    : in  request; accepted when not busy (IDLE or DONE)
//   a, b     : in  [WIDTH-1:0] operands
//   c_in     : in  carry into bit 0
//   sub      : in  subtract select (only with SUBTRACT_EN)
//   busy     : out high exactly while in RUN
//   done     : out one-cycle pulse, result valid
//   sum      : out [WIDTH-1:0] result
//   carry    : out carry out of bit WIDTH-1
//   overflow : out two's-complement signed overflow
// -----------------------------------------------------------------------------
module multicycle_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int N     = (CHUNK > 0) ? (WIDTH / CHUNK) : 1;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  // Elaboration-time parameter checks.
  if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("multicycle_adder: WIDTH=%0d outside %0d..%0d", WIDTH, MIN_WIDTH, MAX_WIDTH);
  end
  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("multicycle_adder: CHUNK=%0d does not divide WIDTH=%0d", CHUNK, WIDTH);
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q;      // operands shift right one chunk per RUN cycle,
  logic [WIDTH-1:0] b_q;      // so the active chunk is always at [CHUNK-1:0]
  logic             run_c;    // carry between chunks

  logic [WIDTH-1:0] b_sel;
  logic             cin_sel;

  logic [CHUNK-1:0] chunk_s;
  logic             chunk_cout;
  logic             chunk_c_msb;
  logic [WIDTH-1:0] chunk_placed;

  // Operand conditioning at accept time. Subtraction is folded into the
  // operands so the datapath is identical for both operations.
  // NOTE: every output of a combinational block is assigned on all paths
  // (here by a default first) so no latch is inferred.
  always_comb begin
    b_sel   = b;
    cin_sel = c_in;
`ifdef SUBTRACT_EN
    if (sub) begin
      b_sel   = ~b;
      cin_sel = 1'b1;
    end
`endif
  end

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a     (a_q[CHUNK-1:0]),
    .b     (b_q[CHUNK-1:0]),
    .cin   (run_c),
    .s     (chunk_s),
    .cout  (chunk_cout),
    .c_msb (chunk_c_msb)
  );

  // The sum register fills from the top: each new chunk enters at the MSB end
  // while earlier chunks shift down, so after N cycles chunk i sits at
  // sum[i*CHUNK +: CHUNK]. Works unchanged for CHUNK == WIDTH.
  assign chunk_placed = WIDTH'(chunk_s) << (WIDTH - CHUNK);

  // NOTE: all state uses non-blocking assignments so every register sees the
  // pre-edge values of the others, independent of statement order.
  // NOTE: the operand registers are reset along with the control state even
  // though their value is don't-care in IDLE; it keeps the datapath free of X
  // after reset and costs nothing at this size.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      run_c    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b_sel;
            run_c <= cin_sel;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          // start is deliberately not looked at here.
          a_q   <= a_q >> CHUNK;
          b_q   <= b_q >> CHUNK;
          run_c <= chunk_cout;
          sum   <= (sum >> CHUNK) | chunk_placed;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            carry    <= chunk_cout;
            overflow <= chunk_c_msb ^ chunk_cout;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_adder.sv
// -----------------------------------------------------------------------------
// tb_multicycle_adder
// Directed, table-driven bench for multicycle_adder (WIDTH=8, CHUNK=2) plus a
// single-cycle instance (WIDTH=16, CHUNK=16). Subtraction vectors are compiled
// in when SUBTRACT_EN is defined.
// -----------------------------------------------------------------------------
module tb_multicycle_adder;

  logic clk;
  logic rst_n;

  // 8-bit, 2-bit chunk instance
  logic       start;
  logic [7:0] a, b;
  logic       c_in;
  logic       busy, done;
  logic [7:0] sum;
  logic       carry, overflow;
`ifdef SUBTRACT_EN
  logic       sub;
  logic       sub16;
`endif

  // 16-bit, single-chunk instance
  logic        start16;
  logic [15:0] a16, b16;
  logic        c_in16;
  logic        busy16, done16;
  logic [15:0] sum16;
  logic        carry16, overflow16;

  int checks = 0;
  int errors = 0;

  multicycle_adder #(.WIDTH(8), .CHUNK(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
`ifdef SUBTRACT_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carry    (carry),
    .overflow (overflow)
  );

  multicycle_adder #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start16),
    .a        (a16),
    .b        (b16),
    .c_in     (c_in16),
`ifdef SUBTRACT_EN
    .sub      (sub16),
`endif
    .busy     (busy16),
    .done     (done16),
    .sum      (sum16),
    .carry    (carry16),
    .overflow (overflow16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock; leaves time 1 unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one 8-bit operation and return the number of edges after the
  // accepting edge until done is seen (bounded).
  task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                      input string tag, output int cyc);
    a     = av;
    b     = bv;
    c_in  = cv;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, " busy after accept"}, 64'(busy), 64'd1);
    cyc = 0;
    while (!done && cyc < 20) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int n_done;

    vecs[0] = '{8'd100, 8'd100, 1'b1, 8'd201, 1'b0, 1'b1};
    vecs[1] = '{8'd200, 8'd200, 1'b0, 8'd144, 1'b1, 1'b0};
    vecs[2] = '{8'd159, 8'd231, 1'b0, 8'd134, 1'b1, 1'b0};
    vecs[3] = '{8'd50,  8'd13,  1'b0, 8'd63,  1'b0, 1'b0};
    vecs[4] = '{8'd67,  8'd22,  1'b1, 8'd90,  1'b0, 1'b0};
    vecs[5] = '{8'd255, 8'd0,   1'b1, 8'd0,   1'b1, 1'b0};
    vecs[6] = '{8'd127, 8'd0,   1'b1, 8'd128, 1'b0, 1'b1};
    vecs[7] = '{8'd128, 8'd128, 1'b0, 8'd0,   1'b1, 1'b1};
    vecs[8] = '{8'd0,   8'd0,   1'b0, 8'd0,   1'b0, 1'b0};
    vecs[9] = '{8'd85,  8'd170, 1'b0, 8'd255, 1'b0, 1'b0};

    rst_n   = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    c_in    = 1'b0;
    start16 = 1'b0;
    a16     = '0;
    b16     = '0;
    c_in16  = 1'b0;
`ifdef SUBTRACT_EN
    sub     = 1'b0;
    sub16   = 1'b0;
`endif

    // Reset state
    #12;
    check("reset busy",     64'(busy),     64'd0);
    check("reset done",     64'(done),     64'd0);
    check("reset sum",      64'(sum),      64'd0);
    check("reset carry",    64'(carry),    64'd0);
    check("reset overflow", 64'(overflow), 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Table-driven additions: latency, result, one-cycle done pulse.
    for (int i = 0; i < 10; i++) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, $sformatf("vec%0d", i), cyc);
      check($sformatf("vec%0d latency", i),  64'(cyc),      64'd4);
      check($sformatf("vec%0d sum", i),      64'(sum),      64'(vecs[i].sum));
      check($sformatf("vec%0d carry", i),    64'(carry),    64'(vecs[i].carry));
      check($sformatf("vec%0d overflow", i), 64'(overflow), 64'(vecs[i].ovf));
      step();
      check($sformatf("vec%0d done pulse", i), 64'(done), 64'd0);
      check($sformatf("vec%0d sum hold", i),   64'(sum),  64'(vecs[i].sum));
    end

    // Back-to-back with ignored start pulses during RUN.
    a = 8'd159; b = 8'd231; c_in = 1'b0; start = 1'b1;
    step();
    start = 1'b0; a = 8'd1; b = 8'd1;
    cyc = 0;
    step(); cyc++;
    start = 1'b1;
    step(); cyc++;
    start = 1'b0;
    while (!done && cyc < 20) begin step(); cyc++; end
    check("b2b first latency", 64'(cyc),   64'd4);
    check("b2b first sum",     64'(sum),   64'd134);
    check("b2b first carry",   64'(carry), 64'd1);
    a = 8'd50; b = 8'd13; c_in = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    check("b2b accepted in DONE", 64'(busy), 64'd1);
    a = 8'd200; b = 8'd200; start = 1'b1;
    step(); cyc++;
    start = 1'b0;
    while (!done && cyc < 20) begin step(); cyc++; end
    check("b2b done spacing", 64'(cyc),   64'd5);
    check("b2b second sum",   64'(sum),   64'd63);
    check("b2b second carry", 64'(carry), 64'd0);
    step();

    // Reset asserted mid-RUN.
    a = 8'd102; b = 8'd255; c_in = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("midrun busy before reset", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrun reset busy",     64'(busy),     64'd0);
    check("midrun reset done",     64'(done),     64'd0);
    check("midrun reset sum",      64'(sum),      64'd0);
    check("midrun reset carry",    64'(carry),    64'd0);
    check("midrun reset overflow", 64'(overflow), 64'd0);
    step();
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) n_done++;
    end
    check("midrun no done after release", 64'(n_done), 64'd0);
    check("midrun idle after release",    64'(busy),   64'd0);
    run8(8'd67, 8'd22, 1'b1, "post reset", cyc);
    check("post reset latency", 64'(cyc), 64'd4);
    check("post reset sum",     64'(sum), 64'd90);
    step();

    // Start already high when reset releases: first edge samples it.
    rst_n = 1'b0;
    a = 8'd1; b = 8'd2; c_in = 1'b0; start = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    start = 1'b0;
    check("start at release accepted", 64'(busy), 64'd1);
    cyc = 0;
    while (!done && cyc < 20) begin step(); cyc++; end
    check("start at release sum", 64'(sum), 64'd3);
    step();

    // Single-chunk instance.
    a16 = 16'hFFFF; b16 = 16'h0001; c_in16 = 1'b0; start16 = 1'b1;
    step();
    start16 = 1'b0;
    check("w16 busy", 64'(busy16), 64'd1);
    cyc = 0;
    while (!done16 && cyc < 20) begin step(); cyc++; end
    check("w16 latency",  64'(cyc),        64'd1);
    check("w16 sum",      64'(sum16),      64'd0);
    check("w16 carry",    64'(carry16),    64'd1);
    check("w16 overflow", 64'(overflow16), 64'd0);
    step();

`ifdef SUBTRACT_EN
    // Subtraction: c_in driven high to show it is ignored.
    sub = 1'b1;
    run8(8'd50, 8'd13, 1'b1, "sub 50-13", cyc);
    check("sub 50-13 latency",  64'(cyc),      64'd4);
    check("sub 50-13 sum",      64'(sum),      64'd37);
    check("sub 50-13 carry",    64'(carry),    64'd1);
    check("sub 50-13 overflow", 64'(overflow), 64'd0);
    step();
    run8(8'd13, 8'd50, 1'b1, "sub 13-50", cyc);
    check("sub 13-50 sum",      64'(sum),      64'd219);
    check("sub 13-50 carry",    64'(carry),    64'd0);
    check("sub 13-50 overflow", 64'(overflow), 64'd0);
    step();
    sub = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
